// File: rtl/fetch_pc_stage.sv
// Fetch-stage program counter and F/D pipeline register with illegal-fetch
// bubble insertion and fetched/stalled cycle counters.
module fetch_pc_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      npc,
  input  logic [31:0]      im_instr,
  output logic [31:0]      F_PC,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      D_PC,
  output logic [31:0]      D_instr,
  output logic             D_valid,
  output logic             F_fetch_err,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      stall_cnt
);

  localparam logic [31:0] PC_LAST = PC_INIT + 32'(4 * IM_WORDS) - 32'd4;

  logic [31:0] f_pc_q,      f_pc_d;
  logic [31:0] d_pc_q,      d_pc_d;
  logic [31:0] d_instr_q,   d_instr_d;
  logic        d_valid_q,   d_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        fetch_err;

  // Out-of-window PCs still produce an index; the memory data is discarded.
  always_comb begin
    fetch_err = (f_pc_q[1:0] != 2'b00) || (f_pc_q < PC_INIT) || (f_pc_q > PC_LAST);
    im_addr   = IM_AW'((f_pc_q - PC_INIT) >> 2);
  end

  always_comb begin
    // NOTE: every next-state signal is given its hold value first so no path
    // through this block leaves one unassigned and infers a latch.
    f_pc_d      = f_pc_q;
    d_pc_d      = d_pc_q;
    d_instr_d   = d_instr_q;
    d_valid_d   = d_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (stall) begin
      // A stall freezes the whole stage, even over a pending fetch error.
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      f_pc_d    = npc;
      d_pc_d    = f_pc_q;
      d_instr_d = fetch_err ? 32'h0 : im_instr;
      d_valid_d = ~fetch_err;
      if (!fetch_err) fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q      <= PC_INIT;
      d_pc_q      <= 32'h0;
      d_instr_q   <= 32'h0;
      d_valid_q   <= 1'b0;
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      f_pc_q      <= f_pc_d;
      d_pc_q      <= d_pc_d;
      d_instr_q   <= d_instr_d;
      d_valid_q   <= d_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign F_PC        = f_pc_q;
  assign D_PC        = d_pc_q;
  assign D_instr     = d_instr_q;
  assign D_valid     = d_valid_q;
  assign F_fetch_err = fetch_err;
  assign fetch_cnt   = fetch_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: a reference model pushes the expected
// post-edge state into a scoreboard queue, popped and compared after each edge.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic [31:0] im_instr;
  logic [31:0] F_PC;
  logic [11:0] im_addr;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_valid;
  logic        F_fetch_err;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [31:0] m_fpc, m_dpc, m_dinstr, m_fcnt, m_scnt;
  logic        m_dvalid;

  fetch_pc_stage #(
    .PC_INIT (32'h0000_3000),
    .IM_WORDS(4096),
    .IM_AW   (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc        (npc),
    .im_instr   (im_instr),
    .F_PC       (F_PC),
    .im_addr    (im_addr),
    .D_PC       (D_PC),
    .D_instr    (D_instr),
    .D_valid    (D_valid),
    .F_fetch_err(F_fetch_err),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds 32'h1000_0000 + k.
  assign im_instr = 32'h1000_0000 + {20'd0, im_addr};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic model_err(logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFC);
  endfunction

  function automatic logic [31:0] model_idx(logic [31:0] pc);
    logic [31:0] off;
    off = (pc - 32'h3000) >> 2;
    return {20'd0, off[11:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_fpc    = 32'h3000;
    m_dpc    = 32'h0;
    m_dinstr = 32'h0;
    m_dvalid = 1'b0;
    m_fcnt   = 32'h0;
    m_scnt   = 32'h0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".F_PC"},      F_PC,              32'h3000);
    check({tag, ".D_PC"},      D_PC,              32'h0);
    check({tag, ".D_instr"},   D_instr,           32'h0);
    check({tag, ".D_valid"},   {31'd0, D_valid},  32'h0);
    check({tag, ".fetch_cnt"}, fetch_cnt,         32'h0);
    check({tag, ".stall_cnt"}, stall_cnt,         32'h0);
  endtask

  // Drive one cycle: check the combinational outputs, push the expected
  // post-edge state, clock, then pop and compare.
  task automatic step(input string tag, input logic st, input logic [31:0] nx);
    exp_t e, got;
    logic err;
    stall = st;
    npc   = nx;
    #1;
    err = model_err(m_fpc);
    check({tag, ".F_fetch_err"}, {31'd0, F_fetch_err}, {31'd0, err});
    check({tag, ".im_addr"},     {20'd0, im_addr},     model_idx(m_fpc));

    if (st) begin
      m_scnt = m_scnt + 32'd1;
    end else begin
      m_dpc    = m_fpc;
      m_dinstr = err ? 32'h0 : 32'h1000_0000 + model_idx(m_fpc);
      m_dvalid = ~err;
      if (!err) m_fcnt = m_fcnt + 32'd1;
      m_fpc    = nx;
    end
    e = '{tag, m_fpc, m_dpc, m_dinstr, m_dvalid, m_fcnt, m_scnt};
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, ".F_PC"},      F_PC,             got.f_pc);
    check({got.tag, ".D_PC"},      D_PC,             got.d_pc);
    check({got.tag, ".D_instr"},   D_instr,          got.d_instr);
    check({got.tag, ".D_valid"},   {31'd0, D_valid}, {31'd0, got.d_valid});
    check({got.tag, ".fetch_cnt"}, fetch_cnt,        got.fetch_cnt);
    check({got.tag, ".stall_cnt"}, stall_cnt,        got.stall_cnt);
  endtask

  initial begin
    logic [31:0] saved_fcnt;
    reset = 1'b1;
    stall = 1'b0;
    npc   = 32'h0000_3004;
    model_reset();
    #12;
    check_reset_state("reset");
    #1 reset = 1'b0;

    // Sequential fetch.
    for (int i = 0; i < 3; i++) step("seq", 1'b0, m_fpc + 32'd4);
    check("seq3.F_PC",      F_PC,      32'h300C);
    check("seq3.D_PC",      D_PC,      32'h3008);
    check("seq3.D_instr",   D_instr,   32'h1000_0002);
    check("seq3.fetch_cnt", fetch_cnt, 32'd3);

    // Branch redirect from 0x3010.
    step("seq4", 1'b0, m_fpc + 32'd4);
    step("br_take", 1'b0, 32'h3040);
    check("br.F_PC", F_PC, 32'h3040);
    check("br.D_PC", D_PC, 32'h3010);
    step("br_next", 1'b0, m_fpc + 32'd4);
    check("br_next.F_PC", F_PC, 32'h3044);
    check("br_next.D_PC", D_PC, 32'h3040);

    // Stall with F_PC=0x3020, D_PC=0x301C while npc wanders.
    step("to_301c", 1'b0, 32'h301C);
    step("to_3020", 1'b0, m_fpc + 32'd4);
    saved_fcnt = m_fcnt;
    step("stall1", 1'b1, 32'hDEAD_0000);
    step("stall2", 1'b1, 32'h3100);
    check("stall.F_PC",      F_PC,      32'h3020);
    check("stall.D_PC",      D_PC,      32'h301C);
    check("stall.stall_cnt", stall_cnt, 32'd2);
    check("stall.fetch_cnt", fetch_cnt, saved_fcnt);
    step("unstall", 1'b0, 32'h3024);
    check("unstall.F_PC", F_PC, 32'h3024);

    // Misaligned target, with a stall landing on the erroneous PC.
    step("mis_load", 1'b0, 32'h3002);
    check("mis.F_fetch_err", {31'd0, F_fetch_err}, 32'd1);
    step("mis_stall", 1'b1, 32'h3008);
    saved_fcnt = fetch_cnt;
    step("mis_bubble", 1'b0, 32'h3008);
    check("mis.D_valid",   {31'd0, D_valid}, 32'd0);
    check("mis.fetch_cnt", fetch_cnt,        saved_fcnt);

    // Window bounds: below start, past end, last legal word.
    step("lo_load", 1'b0, 32'h2FFC);
    step("hi_load", 1'b0, 32'h7000);
    check("hi.F_fetch_err", {31'd0, F_fetch_err}, 32'd1);
    step("last_load", 1'b0, 32'h6FFC);
    check("last.F_fetch_err", {31'd0, F_fetch_err}, 32'd0);
    check("last.im_addr",     {20'd0, im_addr},     32'h0FFF);
    step("last_fetch", 1'b0, 32'h3000);
    check("last.D_instr", D_instr, 32'h1000_0FFF);
    step("run1", 1'b0, m_fpc + 32'd4);
    step("run2", 1'b1, m_fpc + 32'd4);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_reset_state("async_rst");
    #2 reset = 1'b0;
    step("post_rst", 1'b0, 32'h3004);
    check("post_rst.D_PC",    D_PC,    32'h3000);
    check("post_rst.D_instr", D_instr, 32'h1000_0000);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- Holds the fetch-stage program counter and the F/D pipeline register, and is the consumer of the next-PC value computed by the next-PC logic.
- Each cycle it presents F_PC to the instruction memory and to the next-PC logic, captures the fetched instruction into the D stage, and loads npc as the new F_PC.
- It also detects illegal fetch addresses, inserts NOP bubbles in their place, and counts fetched and stalled cycles for bench bookkeeping.

Parameters:
- PC_INIT, 32'h0000_3000, reset value of F_PC (start of the text segment).
- IM_WORDS, 4096, number of instruction words in the instruction memory; the legal fetch window is PC_INIT to PC_INIT+4*IM_WORDS-4.
- IM_AW, 12, width of the word index sent to the instruction memory; IM_WORDS must equal 2**IM_AW.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- stall, input, 1, from the hazard unit; freezes F_PC and the F/D register.
- npc, input, 32, next PC from the next-PC logic; valid every cycle.
- im_instr, input, 32, instruction word returned combinationally for im_addr.
- F_PC, output, 32, current fetch PC; fed back to the next-PC logic.
- im_addr, output, IM_AW, word index (F_PC-PC_INIT)>>2, truncated to IM_AW bits.
- D_PC, output, 32, PC of the instruction held in the D stage.
- D_instr, output, 32, instruction held in the D stage.
- D_valid, output, 1, 1 = D holds a real instruction; 0 = bubble.
- F_fetch_err, output, 1, combinational; current F_PC is misaligned or outside the legal window.
- fetch_cnt, output, 32, count of valid instructions captured into D.
- stall_cnt, output, 32, count of cycles with stall=1 (excluding cycles in reset).

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately and while held):
  - F_PC=PC_INIT.
  - D_PC=0, D_instr=0, D_valid=0.
  - fetch_cnt=0, stall_cnt=0.
- Reset released mid-operation: the first rising edge after deassertion performs a normal update from F_PC=PC_INIT. No partial state survives.
- F_fetch_err = (F_PC[1:0]!=0) OR (F_PC<PC_INIT) OR (F_PC>PC_INIT+4*IM_WORDS-4). All comparisons are 32-bit unsigned.
- im_addr is always driven, including when F_fetch_err=1; the memory data is ignored in that case.
- Normal edge (stall=0):
  - F_PC<=npc.
  - D_PC<=F_PC.
  - D_instr<= F_fetch_err ? 32'h0 : im_instr.
  - D_valid<= ~F_fetch_err.
  - fetch_cnt increments by 1 only when F_fetch_err=0.
- Stall edge (stall=1):
  - F_PC, D_PC, D_instr, D_valid and fetch_cnt hold.
  - stall_cnt increments.
  - npc is ignored on stall edges. The next-PC logic holds branch decisions stable while stalled, so re-sampling npc after the stall yields the same target.
- Delay slots: no flush input. The instruction after a branch or jump always enters D, which gives MIPS delay-slot semantics.
- npc is taken verbatim. No alignment correction is applied; a bad target surfaces as F_fetch_err on the following cycle.
- Latency: npc presented in cycle n becomes F_PC in cycle n+1. The instruction at that F_PC appears on D_instr in cycle n+2 if there is no stall.
- Counter wrap: fetch_cnt and stall_cnt wrap modulo 2**32 silently.
- Simultaneous stall=1 and F_fetch_err=1: stall wins and nothing changes except stall_cnt.

Test Plan:
1. Reset, then 3 edges with stall=0, npc=F_PC+4, and memory word k = 32'h1000_0000+k:
   - F_PC goes 0x3000→0x3004→0x3008→0x300C.
   - D_PC=0x3008 and D_instr=32'h1000_0002 after edge 3.
   - D_valid=1, fetch_cnt=3.
2. Branch redirect: at F_PC=0x3010 drive npc=0x3040 for one edge, then F_PC+4:
   - F_PC=0x3040, then 0x3044.
   - D_PC sequence 0x3010, 0x3040.
3. Stall: assert stall for 2 edges while F_PC=0x3020 and D_PC=0x301C, varying npc:
   - F_PC, D_PC and D_instr remain unchanged.
   - stall_cnt=2, fetch_cnt unchanged.
   - After release, the next edge loads npc.
4. Illegal fetch, part A: npc=0x3002 (misaligned):
   - F_fetch_err=1 in the next cycle.
   - The following edge gives D_instr=0, D_valid=0, and fetch_cnt does not increment.
5. Illegal fetch, part B: npc=0x7000 (outside the window):
   - F_fetch_err=1, with the same bubble behaviour as part A.
   - npc=0x6FFC is the last legal word: F_fetch_err=0, im_addr=12'hFFF.
6. Mid-run async reset: assert reset between edges:
   - F_PC returns to 0x3000, D_valid=0 and both counters read 0 immediately, without waiting for an edge.
   - After release, the first edge captures the instruction at 0x3000.
